// File: rtl/addsub_chunk_seq.sv
// rtl/addsub_chunk_seq.sv - chunked W-bit add/subtract with registered carry chain and valid/ready handshakes
module addsub_chunk_seq #(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic         AddSub_i_Clk,
  input  logic         AddSub_i_Rst,
  input  logic         AddSub_i_Valid,
  output logic         AddSub_o_Ready,
  input  logic [W-1:0] AddSub_i_A,
  input  logic [W-1:0] AddSub_i_B,
  input  logic         AddSub_i_fSub,
  output logic         AddSub_o_Valid,
  input  logic         AddSub_i_Ready,
  output logic [W-1:0] AddSub_o_S,
  output logic         AddSub_o_C,
  output logic         AddSub_o_V,
  output logic         AddSub_o_Z
);

  // number of chunks, counter width and bit-offset width
  localparam int N  = W / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // operands captured at acceptance; B is pre-inverted for subtract
  logic [W-1:0]  a_q;
  logic [W-1:0]  bx_q;
  // partial result being assembled chunk by chunk
  logic [W-1:0]  work_q;
  logic [CW-1:0] cnt;
  logic          carry;

  // visible result registers, only updated on completion
  logic [W-1:0]  s_q;
  logic          c_q;
  logic          v_q;
  logic          z_q;

  logic          last_chunk;
  logic [IW-1:0] base;
  logic [K:0]    chunk_sum;
  logic [W-1:0]  work_nxt;

  assign last_chunk = (cnt == CW'(N - 1));
  // bit offset of the current chunk; always below W so IW bits suffice
  assign base       = IW'(cnt) * IW'(K);

  // one K-bit slice of the ripple add, fed by the carry registered last cycle
  always_comb begin
    chunk_sum = {1'b0, a_q[base +: K]} + {1'b0, bx_q[base +: K]} + {{K{1'b0}}, carry};
    work_nxt  = work_q;
    work_nxt[base +: K] = chunk_sum[K-1:0];
  end

  // state register
  always_ff @(posedge AddSub_i_Clk) begin
    if (AddSub_i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic: accept only in IDLE, finish after the last chunk, release on downstream ready
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (AddSub_i_Valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_chunk) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (AddSub_i_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    AddSub_o_Ready = 1'b0;
    AddSub_o_Valid = 1'b0;
    case (state)
      IDLE:    AddSub_o_Ready = 1'b1;
      DONE:    AddSub_o_Valid = 1'b1;
      default: begin
        AddSub_o_Ready = 1'b0;
        AddSub_o_Valid = 1'b0;
      end
    endcase
  end

  // datapath: capture operands, step one chunk per CALC cycle, publish flags on the last chunk
  always_ff @(posedge AddSub_i_Clk) begin
    if (AddSub_i_Rst) begin
      a_q    <= '0;
      bx_q   <= '0;
      work_q <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AddSub_i_Valid) begin
            a_q   <= AddSub_i_A;
            bx_q  <= AddSub_i_B ^ {W{AddSub_i_fSub}};
            // the +1 of the two's-complement negate enters as the initial carry
            carry <= AddSub_i_fSub;
            cnt   <= '0;
          end
        end
        CALC: begin
          work_q <= work_nxt;
          carry  <= chunk_sum[K];
          cnt    <= cnt + 1'b1;
          if (last_chunk) begin
            s_q <= work_nxt;
            c_q <= chunk_sum[K];
            v_q <= (a_q[W-1] == bx_q[W-1]) && (work_nxt[W-1] != a_q[W-1]);
            z_q <= (work_nxt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign AddSub_o_S = s_q;
  assign AddSub_o_C = c_q;
  assign AddSub_o_V = v_q;
  assign AddSub_o_Z = z_q;

endmodule

// File: tb/tb_addsub_chunk_seq.sv
// tb/tb_addsub_chunk_seq.sv - scoreboard bench for addsub_chunk_seq with K=4, K=16 and K=1 instances
module tb_addsub_chunk_seq;

  localparam int W  = 16;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         sub = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         vld  [NI];
  logic         ordy [NI];
  logic         ov   [NI];
  logic         oc   [NI];
  logic         ovf  [NI];
  logic         oz   [NI];
  logic [W-1:0] os   [NI];

  int pc     = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int           inst;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int           p;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) pc <= pc + 1;

  addsub_chunk_seq #(.W(W), .K(4)) u_k4 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst), .AddSub_i_Valid(vld[0]), .AddSub_o_Ready(ordy[0]),
    .AddSub_i_A(a), .AddSub_i_B(b), .AddSub_i_fSub(sub), .AddSub_o_Valid(ov[0]),
    .AddSub_i_Ready(rdy), .AddSub_o_S(os[0]), .AddSub_o_C(oc[0]), .AddSub_o_V(ovf[0]), .AddSub_o_Z(oz[0])
  );

  addsub_chunk_seq #(.W(W), .K(16)) u_k16 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst), .AddSub_i_Valid(vld[1]), .AddSub_o_Ready(ordy[1]),
    .AddSub_i_A(a), .AddSub_i_B(b), .AddSub_i_fSub(sub), .AddSub_o_Valid(ov[1]),
    .AddSub_i_Ready(rdy), .AddSub_o_S(os[1]), .AddSub_o_C(oc[1]), .AddSub_o_V(ovf[1]), .AddSub_o_Z(oz[1])
  );

  addsub_chunk_seq #(.W(W), .K(1)) u_k1 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst), .AddSub_i_Valid(vld[2]), .AddSub_o_Ready(ordy[2]),
    .AddSub_i_A(a), .AddSub_i_B(b), .AddSub_i_fSub(sub), .AddSub_o_Valid(ov[2]),
    .AddSub_i_Ready(rdy), .AddSub_o_S(os[2]), .AddSub_o_C(oc[2]), .AddSub_o_V(ovf[2]), .AddSub_o_Z(oz[2])
  );

  function automatic int lat_of(int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  // reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(int i, logic [W-1:0] av, logic [W-1:0] bv, logic sv, int p);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      r   = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      r   = ua + ub;
      sr  = sa + sb;
      e.c = (r > 65535);
    end
    e.s    = r[15:0];
    e.v    = (sr > 32767) || (sr < -32768);
    e.z    = (e.s == '0);
    e.inst = i;
    e.p    = p;
    return e;
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // mode 0: plain, 1: toggle inputs during CALC, 2: backpressure 5 cycles, 3: reset mid-CALC
  task automatic request(int i, logic [W-1:0] av, logic [W-1:0] bv, logic sv, int mode);
    int   guard;
    int   n;
    exp_t e;
    n      = lat_of(i);
    a      = av;
    b      = bv;
    sub    = sv;
    vld[i] = 1'b1;
    guard  = 0;
    while (!ordy[i] && guard < 50) begin
      tick();
      guard++;
    end
    if (!ordy[i]) begin
      n_chk++;
      $display("FAIL accept_timeout inst%0d: got o_Ready 0 expected 1 within 50 cycles", i);
      vld[i] = 1'b0;
      return;
    end
    e = model(i, av, bv, sv, pc);
    if (mode != 3) q.push_back(e);
    if (mode == 2) rdy = 1'b0;
    tick();
    vld[i] = 1'b0;
    a      = 16'($urandom);
    b      = 16'($urandom);
    sub    = 1'($urandom);
    if (mode == 1) begin
      for (int k = 0; k < n; k++) begin
        vld[i] = 1'($urandom_range(0, 1));
        a      = 16'($urandom);
        tick();
      end
      vld[i] = 1'b0;
    end
    if (mode == 3) begin
      if (n > 1) tick();
      rst = 1'b1;
      tick();
      chk("rst_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_ready", i, 32'(ordy[i]), 32'd1);
      chk("rst_s", i, 32'(os[i]), 32'd0);
      chk("rst_cvz", i, {29'd0, oc[i], ovf[i], oz[i]}, 32'd0);
      rst = 1'b0;
      return;
    end
    guard = 0;
    while (!ov[i] && guard < 40) begin
      tick();
      guard++;
    end
    if (!ov[i]) begin
      n_chk++;
      $display("FAIL done_timeout inst%0d: got o_Valid 0 expected 1 within 40 cycles", i);
      rdy = 1'b1;
      return;
    end
    if (mode == 2) begin
      for (int k = 0; k < 5; k++) begin
        chk("bp_valid", i, 32'(ov[i]), 32'd1);
        chk("bp_ready", i, 32'(ordy[i]), 32'd0);
        chk("bp_s", i, 32'(os[i]), 32'(e.s));
        chk("bp_cvz", i, {29'd0, oc[i], ovf[i], oz[i]}, {29'd0, e.c, e.v, e.z});
        tick();
      end
      rdy = 1'b1;
    end
    tick();
    chk("post_valid", i, 32'(ov[i]), 32'd0);
    chk("post_ready", i, 32'(ordy[i]), 32'd1);
  endtask

  // monitor: latency on o_Valid rise, result compare on output handshake
  logic ov_d [NI];
  exp_t m;
  initial begin
    for (int i = 0; i < NI; i++) ov_d[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && !ov_d[i]) begin
          if (q.size() == 0 || q[0].inst != i) begin
            n_chk++;
            $display("FAIL unexpected_result inst%0d: got o_Valid 1 expected no pending request", i);
          end else begin
            chk("latency", i, 32'(pc - q[0].p - 1), 32'(lat_of(i)));
          end
        end
        if (ov[i] && rdy && q.size() > 0 && q[0].inst == i) begin
          m = q.pop_front();
          chk("s", i, 32'(os[i]), 32'(m.s));
          chk("c", i, 32'(oc[i]), 32'(m.c));
          chk("v", i, 32'(ovf[i]), 32'(m.v));
          chk("z", i, 32'(oz[i]), 32'(m.z));
        end
        ov_d[i] = ov[i];
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) vld[i] = 1'b0;
    rst = 1'b1;
    rdy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_valid", i, 32'(ov[i]), 32'd0);
      chk("reset_ready", i, 32'(ordy[i]), 32'd1);
      chk("reset_s", i, 32'(os[i]), 32'd0);
      chk("reset_cvz", i, {29'd0, oc[i], ovf[i], oz[i]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    request(0, 16'hF7F8, 16'h7961, 1'b1, 0);
    request(0, 16'hE5E1, 16'h73A3, 1'b0, 0);
    request(0, 16'h3F1B, 16'h46EA, 1'b0, 0);
    request(0, 16'h1234, 16'h1234, 1'b1, 0);
    request(0, 16'h0000, 16'h0001, 1'b1, 0);
    request(0, 16'h8000, 16'h0001, 1'b1, 2);
    request(0, 16'h7FFF, 16'h0001, 1'b0, 1);
    request(0, 16'hABCD, 16'h1111, 1'b0, 3);
    request(0, 16'h0F0F, 16'hF0F1, 1'b0, 0);

    for (int i = 1; i < NI; i++) begin
      request(i, 16'hF7F8, 16'h7961, 1'b1, 0);
      request(i, 16'h5555, 16'h2222, 1'b0, 3);
      request(i, 16'h1234, 16'h1234, 1'b1, 0);
      request(i, 16'($urandom), 16'($urandom), 1'($urandom), 1);
      request(i, 16'($urandom), 16'($urandom), 1'($urandom), 2);
    end

    repeat (40) begin
      request($urandom_range(0, NI - 1), 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    repeat (20) tick();
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
